// File: rtl/irq_priority_encoder.sv
// irq_priority_encoder: sequential N-to-W priority encoder with request latching and a
// valid/acknowledge handshake. Requests are OR-ed into a pending register; the highest pending
// index is presented on S with V=1 and held until ACK, which retires that one pending bit.
//
// Ports:
//   clk    - system clock, all state updates on the rising edge
//   rst_n  - synchronous active-low reset
//   E      - enable: 1 = latch R into pending, 0 = ignore R
//   R      - level-sensitive request lines, bit N-1 has highest priority
//   ACK    - consumer acknowledge of the presented code
//   S      - encoded index of the presented request (qualify with V)
//   V      - S is valid
//   P      - pending register non-zero (includes the presented request)
//
// N must equal 2**W.
module irq_priority_encoder #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         E,
    input  logic [N-1:0] R,
    input  logic         ACK,
    output logic [W-1:0] S,
    output logic         V,
    output logic         P
);

    typedef enum logic [0:0] {StIdle, StPresent} state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   pend_q, pend_d;
    logic [W-1:0]   s_q, s_d;
    logic           p_q, p_d;
    logic [N-1:0]   clr;
    logic [W-1:0]   top_idx;

    // Highest set index of the registered pend; later iterations override earlier ones.
    always_comb begin
        top_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (pend_q[i]) begin
                top_idx = W'(i);
            end
        end
    end

    // Retire the presented bit only when an ACK is accepted in StPresent.
    always_comb begin
        clr = '0;
        if (state_q == StPresent && ACK) begin
            clr[s_q] = 1'b1;
        end
    end

    // A request on the bit being cleared wins, since R is OR-ed in after the clear.
    always_comb begin
        pend_d = pend_q & ~clr;
        if (E) begin
            pend_d = pend_d | R;
        end
        p_d = |pend_d;
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        unique case (state_q)
            StIdle: begin
                if (pend_q != '0) begin
                    s_d     = top_idx;
                    state_d = StPresent;
                end
            end
            StPresent: begin
                // No preemption: S stays put until ACK.
                if (ACK) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pend_q  <= '0;
            s_q     <= '0;
            p_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            s_q     <= s_d;
            p_q     <= p_d;
        end
    end

    assign S = s_q;
    assign V = (state_q == StPresent);
    assign P = p_q;

endmodule

// File: tb/tb_irq_priority_encoder.sv
module tb_irq_priority_encoder;

    typedef struct {
        logic       rst_n;
        logic       e;
        logic [7:0] r;
        logic       ack;
        logic [2:0] s;
        logic       v;
        logic       p;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       e;
    logic [7:0] r;
    logic       ack;
    logic [2:0] s;
    logic       v;
    logic       p;

    int checks;
    int errors;
    vec_t vecs[$];

    irq_priority_encoder #(
        .N(8),
        .W(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .E    (e),
        .R    (r),
        .ACK  (ack),
        .S    (s),
        .V    (v),
        .P    (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row = inputs applied for one cycle and the outputs expected after that edge.
    function automatic void add(input logic rn, input logic en, input logic [7:0] rq,
                                input logic ak, input logic [2:0] es, input logic ev,
                                input logic ep);
        vec_t t;
        t.rst_n = rn; t.e = en; t.r = rq; t.ack = ak;
        t.s = es; t.v = ev; t.p = ep;
        vecs.push_back(t);
    endfunction

    task automatic check(input string name, input int idx, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0; e = 1'b1; r = 8'hFF; ack = 1'b0;

        // Reset with R=FF held, release with R=FF for one edge, then V+S=7 one edge later.
        add(0, 1, 8'hFF, 0, 3'd0, 0, 0);
        add(0, 1, 8'hFF, 0, 3'd0, 0, 0);
        add(1, 1, 8'hFF, 0, 3'd0, 0, 1);
        add(1, 1, 8'h00, 0, 3'd7, 1, 1);
        add(0, 1, 8'h00, 0, 3'd0, 0, 0);
        // Single request on bit 5; trailing ACK in idle is ignored.
        add(1, 1, 8'h20, 0, 3'd0, 0, 1);
        add(1, 1, 8'h00, 0, 3'd5, 1, 1);
        add(1, 1, 8'h00, 1, 3'd5, 0, 0);
        add(1, 1, 8'h00, 1, 3'd5, 0, 0);
        // Priority order 7, 4, 1 with a one-cycle gap between codes.
        add(1, 1, 8'h92, 0, 3'd5, 0, 1);
        add(1, 1, 8'h00, 0, 3'd7, 1, 1);
        add(1, 1, 8'h00, 1, 3'd7, 0, 1);
        add(1, 1, 8'h00, 0, 3'd4, 1, 1);
        add(1, 1, 8'h00, 1, 3'd4, 0, 1);
        add(1, 1, 8'h00, 0, 3'd1, 1, 1);
        add(1, 1, 8'h00, 1, 3'd1, 0, 0);
        // No preemption by bit 6; bit 2 re-requested during its ACK stays pending.
        add(1, 1, 8'h04, 0, 3'd1, 0, 1);
        add(1, 1, 8'h00, 0, 3'd2, 1, 1);
        add(1, 1, 8'h40, 0, 3'd2, 1, 1);
        add(1, 1, 8'h04, 1, 3'd2, 0, 1);
        add(1, 1, 8'h00, 0, 3'd6, 1, 1);
        add(1, 1, 8'h00, 1, 3'd6, 0, 1);
        add(1, 1, 8'h00, 0, 3'd2, 1, 1);
        add(1, 1, 8'h00, 1, 3'd2, 0, 0);
        // Enable gating: E=0 blocks R entirely.
        for (int k = 0; k < 5; k++) add(1, 0, 8'hFF, 0, 3'd2, 0, 0);
        add(1, 1, 8'hFF, 0, 3'd2, 0, 1);
        add(1, 0, 8'hFF, 0, 3'd7, 1, 1);
        // E=0 while presenting: every code 7..0 still drains via ACK.
        for (int k = 7; k >= 0; k--) begin
            add(1, 0, 8'hFF, 1, 3'(k), 0, (k != 0));
            if (k > 0) add(1, 0, 8'hFF, 0, 3'(k - 1), 1, 1);
        end

        #1;
        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n; e = vecs[i].e; r = vecs[i].r; ack = vecs[i].ack;
            step();
            check("S", i, {5'd0, s}, {5'd0, vecs[i].s});
            check("V", i, {7'd0, v}, {7'd0, vecs[i].v});
            check("P", i, {7'd0, p}, {7'd0, vecs[i].p});
        end

        // Reset mid-presentation: present code 3 with bit 1 also pending, then reset.
        rst_n = 1'b1; e = 1'b1; ack = 1'b0; r = 8'h0A;
        step();
        r = 8'h00;
        begin
            int n;
            n = 0;
            step();
            while (v !== 1'b1 && n < 10) begin
                step();
                n++;
            end
            check("wait_v", n, {7'd0, v}, 8'd1);
        end
        check("mid_s", 0, {5'd0, s}, 8'd3);
        check("mid_p", 0, {7'd0, p}, 8'd1);
        rst_n = 1'b0;
        step();
        check("rst_v", 0, {7'd0, v}, 8'd0);
        check("rst_p", 0, {7'd0, p}, 8'd0);
        check("rst_s", 0, {5'd0, s}, 8'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check("post_rst_v", k, {7'd0, v}, 8'd0);
            check("post_rst_p", k, {7'd0, p}, 8'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
